// File: rtl/can_tx_frame_serializer.sv
// rtl/can_tx_frame_serializer.sv - CAN base-format frame transmitter with bit stuffing, CRC-15 and bus monitoring
module can_tx_frame_serializer #(
    parameter int MAX_DATA_BYTES = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        reset_mode_i,
    input  logic        tx_point_i,
    input  logic        sample_point_i,
    input  logic        rx_bit_i,
    input  logic        bus_idle_i,
    input  logic        tx_request_i,
    input  logic [10:0] id_i,
    input  logic        rtr_i,
    input  logic [3:0]  dlc_i,
    input  logic [63:0] data_i,
    output logic        tx_o,
    output logic        tx_busy_o,
    output logic        go_oc_transmitting_o,
    output logic        go_oc_receiving_o,
    output logic        tx_done_o,
    output logic        arb_lost_o,
    output logic        bit_error_o,
    output logic        ack_error_o
);
    typedef enum logic [2:0] {
        S_IDLE, S_STUFFED, S_CRC_DELIM, S_ACK_SLOT, S_ACK_DELIM, S_EOF
    } state_t;

    localparam logic [3:0]  MAX_DLC  = 4'(MAX_DATA_BYTES);
    localparam logic [14:0] CRC_POLY = 15'h4599;

    state_t      state, state_n;
    // Every unstuffed bit after SOF up to the last data bit; the next one sits at the MSB.
    logic [81:0] frame_sr, frame_sr_n;
    logic        rtr_q, rtr_n;
    logic [3:0]  dlc_q, dlc_n;
    logic [14:0] crc_q, crc_n;
    logic [6:0]  idx_q, idx_n;
    logic [2:0]  run_q, run_n;
    logic        stuff_q, stuff_n;
    logic [2:0]  eof_q, eof_n;
    logic        tx_n, go_tx_n, go_rx_n, done_n, arb_n, berr_n, aerr_n;

    logic [3:0]  dlc_eff;
    logic [6:0]  crc_first, crc_last, nidx;
    logic        nbit, in_arb, arst;

    assign arst      = rst_i | reset_mode_i;
    assign dlc_eff   = (dlc_q > MAX_DLC) ? MAX_DLC : dlc_q;
    assign crc_first = rtr_q ? 7'd19 : 7'd19 + {dlc_eff, 3'b000};
    assign crc_last  = crc_first + 7'd14;
    assign nidx      = idx_q + 7'd1;
    assign nbit      = (nidx < crc_first) ? frame_sr[81] : crc_q[14];
    // idx_q is the last unstuffed bit driven; a stuff bit after the RTR bit is outside arbitration.
    assign in_arb    = (idx_q != 7'd0) && (stuff_q ? (idx_q <= 7'd11) : (idx_q <= 7'd12));
    assign tx_busy_o = (state != S_IDLE);

    function automatic logic [14:0] crc_step(input logic [14:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[14];
        return {crc[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'd0);
    endfunction

    always_ff @(posedge clk_i or posedge arst) begin
        if (arst) begin
            state                <= S_IDLE;
            tx_o                 <= 1'b1;
            frame_sr             <= '0;
            rtr_q                <= 1'b0;
            dlc_q                <= '0;
            crc_q                <= '0;
            idx_q                <= '0;
            run_q                <= '0;
            stuff_q              <= 1'b0;
            eof_q                <= '0;
            go_oc_transmitting_o <= 1'b0;
            go_oc_receiving_o    <= 1'b0;
            tx_done_o            <= 1'b0;
            arb_lost_o           <= 1'b0;
            bit_error_o          <= 1'b0;
            ack_error_o          <= 1'b0;
        end else begin
            state                <= state_n;
            tx_o                 <= tx_n;
            frame_sr             <= frame_sr_n;
            rtr_q                <= rtr_n;
            dlc_q                <= dlc_n;
            crc_q                <= crc_n;
            idx_q                <= idx_n;
            run_q                <= run_n;
            stuff_q              <= stuff_n;
            eof_q                <= eof_n;
            go_oc_transmitting_o <= go_tx_n;
            go_oc_receiving_o    <= go_rx_n;
            tx_done_o            <= done_n;
            arb_lost_o           <= arb_n;
            bit_error_o          <= berr_n;
            ack_error_o          <= aerr_n;
        end
    end

    always_comb begin
        state_n    = state;
        tx_n       = tx_o;
        frame_sr_n = frame_sr;
        rtr_n      = rtr_q;
        dlc_n      = dlc_q;
        crc_n      = crc_q;
        idx_n      = idx_q;
        run_n      = run_q;
        stuff_n    = stuff_q;
        eof_n      = eof_q;
        go_tx_n    = 1'b0;
        go_rx_n    = 1'b0;
        done_n     = 1'b0;
        arb_n      = 1'b0;
        berr_n     = 1'b0;
        aerr_n     = 1'b0;
        case (state)
            S_IDLE: begin
                if (tx_point_i && tx_request_i && bus_idle_i) begin
                    state_n    = S_STUFFED;
                    tx_n       = 1'b0;
                    go_tx_n    = 1'b1;
                    frame_sr_n = {id_i, rtr_i, 2'b00, dlc_i, data_i};
                    rtr_n      = rtr_i;
                    dlc_n      = dlc_i;
                    crc_n      = '0;  // a dominant SOF leaves the zero seed unchanged
                    idx_n      = '0;
                    run_n      = 3'd1;
                    stuff_n    = 1'b0;
                end
            end
            S_STUFFED: begin
                // The sample of the current bit is judged before any advance in the same cycle.
                if (sample_point_i && (rx_bit_i != tx_o)) begin
                    state_n = S_IDLE;
                    tx_n    = 1'b1;
                    if (in_arb && tx_o) begin
                        arb_n   = 1'b1;
                        go_rx_n = 1'b1;
                    end else begin
                        berr_n = 1'b1;
                    end
                end else if (tx_point_i) begin
                    if (run_q == 3'd5) begin
                        tx_n    = ~tx_o;
                        run_n   = 3'd1;
                        stuff_n = 1'b1;
                    end else if (idx_q == crc_last) begin
                        state_n = S_CRC_DELIM;
                        tx_n    = 1'b1;
                    end else begin
                        tx_n    = nbit;
                        idx_n   = nidx;
                        stuff_n = 1'b0;
                        run_n   = (nbit == tx_o) ? run_q + 3'd1 : 3'd1;
                        if (nidx < crc_first) begin
                            frame_sr_n = {frame_sr[80:0], 1'b0};
                            crc_n      = crc_step(crc_q, nbit);
                        end else begin
                            crc_n = {crc_q[13:0], 1'b0};
                        end
                    end
                end
            end
            S_CRC_DELIM: begin
                if (sample_point_i) begin
                    if (!rx_bit_i) begin
                        state_n = S_IDLE;
                        berr_n  = 1'b1;
                    end else begin
                        state_n = S_ACK_SLOT;
                    end
                end
            end
            S_ACK_SLOT: begin
                if (sample_point_i) begin
                    if (rx_bit_i) begin
                        state_n = S_IDLE;
                        aerr_n  = 1'b1;
                    end else begin
                        state_n = S_ACK_DELIM;
                    end
                end
            end
            S_ACK_DELIM: begin
                if (sample_point_i) begin
                    if (!rx_bit_i) begin
                        state_n = S_IDLE;
                        berr_n  = 1'b1;
                    end else begin
                        state_n = S_EOF;
                        eof_n   = '0;
                    end
                end
            end
            S_EOF: begin
                if (sample_point_i) begin
                    if (!rx_bit_i) begin
                        state_n = S_IDLE;
                        berr_n  = 1'b1;
                    end else if (eof_q == 3'd6) begin
                        state_n = S_IDLE;
                        done_n  = 1'b1;
                    end else begin
                        eof_n = eof_q + 3'd1;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
    end
endmodule
